// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between the fetch port and the load/store port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_arbiter #(
   parameter int unsigned WAIT_STATES = 0,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_i,
   input  logic [ADDR_W-1:0]     if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_rvalid_o,
   output logic [DATA_W-1:0]     if_rdata_o,
   output logic                  if_stall_o,
   input  logic                  d_req_i,
   input  logic                  d_wen_i,
   input  logic [ADDR_W-1:0]     d_addr_i,
   input  logic [DATA_W-1:0]     d_wdata_i,
   input  logic [DATA_W/8-1:0]   d_wstrb_i,
   output logic                  d_gnt_o,
   output logic                  d_rvalid_o,
   output logic [DATA_W-1:0]     d_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_wen_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   output logic [DATA_W/8-1:0]   mem_wstrb_o,
   input  logic [DATA_W-1:0]     mem_rdata_i
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
   localparam logic       OWN_D  = 1'b0;
   localparam logic       OWN_IF = 1'b1;
   localparam logic [2:0] CNT_LD = 3'(WAIT_STATES);

   state_t                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  owner_q, owner_d;
   logic                  wen_q, wen_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;

   logic resp, window, pick_if, grant_if, grant_d, grant;

   assign resp   = (state_q == BUSY) && (cnt_q == 3'd0);
   assign window = (state_q == IDLE) || resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // rr_q high means fetch wins the next contended window.
   logic rr_q, rr_d;
   assign pick_if = rr_q;
   assign rr_d    = rr_q ^ (grant & if_req_i & d_req_i);

   always_ff @(posedge clk) begin
      if (!rst_n) rr_q <= 1'b0;
      else        rr_q <= rr_d;
   end
`else
   assign pick_if = 1'b0;
`endif

   assign grant_if = window && if_req_i && (!d_req_i || pick_if);
   assign grant_d  = window && d_req_i && (!if_req_i || !pick_if);
   assign grant    = grant_if | grant_d;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         owner_q <= OWN_D;
         wen_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      owner_d = owner_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      case (state_q)
         IDLE: ;
         BUSY: begin
            if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
            else               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A grant in the response cycle overrides the return to IDLE.
      if (grant) begin
         state_d = BUSY;
         cnt_d   = CNT_LD;
         owner_d = grant_if ? OWN_IF : OWN_D;
         wen_d   = grant_d & d_wen_i;
         addr_d  = grant_if ? if_addr_i : d_addr_i;
         wdata_d = grant_if ? '0 : d_wdata_i;
         wstrb_d = grant_if ? '0 : d_wstrb_i;
      end
   end

   // Outputs
   always_comb begin
      if_gnt_o    = grant_if;
      d_gnt_o     = grant_d;
      if_stall_o  = if_req_i & ~grant_if;
      mem_req_o   = (state_q == BUSY);
      mem_wen_o   = wen_q;
      mem_addr_o  = addr_q;
      mem_wdata_o = wdata_q;
      mem_wstrb_o = wstrb_q;
      if_rvalid_o = resp && (owner_q == OWN_IF);
      d_rvalid_o  = resp && (owner_q == OWN_D);
      if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
      d_rdata_o   = (d_rvalid_o && !wen_q) ? mem_rdata_i : '0;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single shared synchronous memory between the instruction-fetch port and the load/store data port of the 5-stage RV32I core. The block grants at most one access per cycle, inserts a programmable number of memory wait states, and returns each response to the port that issued it. A fetch request that loses arbitration or waits on the memory raises a stall that holds the PC in the fetch stage.

## Interface
- WAIT_STATES, default 0: extra memory cycles per access (0..7); response arrives WAIT_STATES+1 cycles after grant.
- ADDR_W, default 32: address width.
- DATA_W, default 32: data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- if_req_i  input  1  fetch request; held with if_addr_i until granted.
- if_addr_i  input  ADDR_W  fetch address (PC).
- if_gnt_o  output  1  fetch accepted this cycle (combinational).
- if_rvalid_o  output  1  fetch data valid (registered).
- if_rdata_o  output  DATA_W  instruction word; valid when if_rvalid_o is high.
- if_stall_o  output  1  if_req_i & ~if_gnt_o; drives the fetch-stage stall.
- d_req_i  input  1  data request; held with its payload until granted.
- d_wen_i  input  1  1 = store, 0 = load.
- d_addr_i  input  ADDR_W  data address.
- d_wdata_i  input  DATA_W  store data.
- d_wstrb_i  input  DATA_W/8  store byte enables.
- d_gnt_o  output  1  data request accepted this cycle.
- d_rvalid_o  output  1  load data valid, or store acknowledge.
- d_rdata_o  output  DATA_W  load data; 0 on store acknowledges.
- mem_req_o  output  1  memory access strobe.
- mem_wen_o / mem_addr_o / mem_wdata_o / mem_wstrb_o  output  1/ADDR_W/DATA_W/DATA_W/8  memory command, held stable during the access.
- mem_rdata_i  input  DATA_W  memory read data, sampled in the response cycle.

## Operation
- States: IDLE (nothing outstanding) and BUSY (access outstanding, wait counter `cnt` active).
- Grant window: in IDLE, or in BUSY when `cnt`==0 (the response cycle). No grant is issued outside this window.
- Arbitration within the window: if only one port requests, that port is granted. If both request, the data port wins in the default build (see Configuration).
- On grant: the memory command is latched from the winning port, mem_req_o is asserted, `owner` is recorded, `cnt` is loaded with WAIT_STATES, and the state becomes BUSY.
- BUSY with `cnt`>0: `cnt` decrements each cycle, the command is held, and both gnt outputs are 0.
- BUSY with `cnt`==0 (response cycle):
  - The owner's rvalid is driven high for one cycle with the memory data.
  - A new grant may be issued in the same cycle. Without a new grant, the state returns to IDLE.
- rdata outputs are 0 whenever the matching rvalid is low.
- Loads and fetches place mem_rdata_i on the owner's rdata. Stores produce an rvalid acknowledge with rdata = 0.
- Address and data pass through unmodified; alignment is not checked.

## Timing
- Reset: state IDLE, `cnt`=0, `owner`=data, round-robin pointer favours data. All outputs are 0 after reset except the combinational gnt and stall outputs, which follow the request inputs.
- Latency: with the grant in cycle t, rvalid is high in cycle t+WAIT_STATES+1.
- Throughput: one access per WAIT_STATES+1 cycles. With WAIT_STATES=0, back-to-back grants occur every cycle.
- Request/grant handshake:
  - req may rise at any time and must be held stable until gnt.
  - Dropping req before gnt withdraws the request.
  - Each port has at most one outstanding access. A port may re-request in its own response cycle and be granted in that cycle.
- Simultaneous requests in the grant window: exactly one grant is issued, and the loser sees gnt=0 (if_stall_o=1 when the loser is fetch).
- Reset mid-access: the outstanding access is abandoned, and no rvalid is produced after reset.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority, data port over fetch. Fetch can be starved by continuous data requests.
- MEM_ARB_ROUND_ROBIN_EN defined: a 1-bit pointer selects the winner on conflict. The pointer flips to favour the other port after every contended grant and is unchanged on uncontended grants; its reset value favours data.

## Test plan
- Fetch only, WAIT_STATES=0: if_req=1 with addr 0x1000, then 0x1004, 0x1008 → if_gnt every cycle; if_rvalid one cycle after each grant with the matching words; if_stall=0.
- Store then load, WAIT_STATES=2:
  - Store 0xDEADBEEF to 0x2000 with strb 0xF → d_rvalid 3 cycles after gnt with rdata 0.
  - Load from 0x2000 → 0xDEADBEEF.
- Contention, default build: both ports request continuously → d_gnt every window; if_gnt never asserted; if_stall=1 throughout.
- Contention, MEM_ARB_ROUND_ROBIN_EN, WAIT_STATES=0: both ports request continuously → grants alternate data, fetch, data, …; each rvalid goes to the correct port.
- Reset mid-access, WAIT_STATES=3: rst_n low one cycle after a fetch grant → no if_rvalid; state IDLE; next request is granted immediately.
- Re-request in response cycle, WAIT_STATES=1: fetch re-requests while if_rvalid=1 → granted in the same cycle, with no idle cycle between accesses.
